// File: rtl/rgb_demux_bank.sv
// Registered N-channel RGB demultiplexer with a shadow bank, atomic commit and write lockout.
// Optional: define RGB_DEMUX_CLEAR_ON_COMMIT_EN to blank the shadow bank on every commit.
module rgb_demux_bank #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned SEL_W    = $clog2(N_CH),
  parameter int unsigned HOLD_CYC = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_W-1:0]        i_din,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic                     i_auto,
  input  logic                     i_commit,
  output logic [N_CH*DATA_W-1:0]   o_rgb,
  output logic                     o_done,
  output logic                     o_err
);

  localparam int unsigned      CntW     = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CntW-1:0]  HoldLoad = (HOLD_CYC > 0) ? CntW'(HOLD_CYC - 1) : '0;
  localparam logic [SEL_W-1:0] LastCh   = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {StLoad, StCommit, StHold} state_e;

  state_e                   state_q;
  logic [DATA_W-1:0]        shadow_q [N_CH];
  logic [SEL_W-1:0]         ptr_q;
  logic [CntW-1:0]          cnt_q;
  logic [N_CH*DATA_W-1:0]   rgb_q;
  logic                     done_q;
  logic                     err_q;

  assign o_ready = (state_q == StLoad) && !i_rst;
  assign o_rgb   = rgb_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StLoad;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rgb_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < N_CH; k++) shadow_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (i_valid) begin
            if (i_auto) begin
              shadow_q[ptr_q] <= i_din;
              ptr_q           <= (ptr_q == LastCh) ? '0 : ptr_q + 1'b1;
            end else if (32'(i_sel) < N_CH) begin
              shadow_q[i_sel] <= i_din;
            end else begin
              // Out-of-range select: the word is consumed but dropped.
              err_q <= 1'b1;
            end
          end
          if (i_commit) state_q <= StCommit;
        end
        StCommit: begin
          for (int k = 0; k < N_CH; k++) begin
            rgb_q[k*DATA_W +: DATA_W] <= shadow_q[k];
`ifdef RGB_DEMUX_CLEAR_ON_COMMIT_EN
            shadow_q[k] <= '0;
`endif
          end
          ptr_q <= '0;
          if (HOLD_CYC > 0) begin
            cnt_q   <= HoldLoad;
            state_q <= StHold;
          end else begin
            done_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StLoad;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_demux_bank.sv
// Self-checking bench for rgb_demux_bank: default instance (4 ch, 16-cycle hold) and a
// 3-channel instance with no hold. Expected banks come from a shadow model via a queue.
module tb_rgb_demux_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] din;
  logic        valid;
  logic        ready;
  logic [1:0]  sel;
  logic        auto_m;
  logic        commit;
  logic [95:0] rgb;
  logic        done;
  logic        err;

  logic [23:0] d3_din;
  logic        d3_valid;
  logic        d3_ready;
  logic [1:0]  d3_sel;
  logic        d3_auto;
  logic        d3_commit;
  logic [71:0] d3_rgb;
  logic        d3_done;
  logic        d3_err;

  int checks = 0;
  int passed = 0;

  logic [23:0] m_sh [4];
  int          m_ptr;
  logic [95:0] exp_q [$];

  always #5 clk = ~clk;

  rgb_demux_bank u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_din    (din),
    .i_valid  (valid),
    .o_ready  (ready),
    .i_sel    (sel),
    .i_auto   (auto_m),
    .i_commit (commit),
    .o_rgb    (rgb),
    .o_done   (done),
    .o_err    (err)
  );

  rgb_demux_bank #(
    .DATA_W   (24),
    .N_CH     (3),
    .HOLD_CYC (0)
  ) u_dut3 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_din    (d3_din),
    .i_valid  (d3_valid),
    .o_ready  (d3_ready),
    .i_sel    (d3_sel),
    .i_auto   (d3_auto),
    .i_commit (d3_commit),
    .o_rgb    (d3_rgb),
    .o_done   (d3_done),
    .o_err    (d3_err)
  );

  function automatic logic [95:0] model_bank();
    return {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
  endfunction

  task automatic model_write(input bit au, input logic [1:0] s, input logic [23:0] d);
    if (au) begin
      m_sh[m_ptr] = d;
      m_ptr = (m_ptr + 1) % 4;
    end else begin
      m_sh[s] = d;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_sh[k] = '0;
    m_ptr = 0;
  endtask

  // Single accepted write; call at a negedge while the DUT is in LOAD.
  task automatic do_write(input bit au, input logic [1:0] s, input logic [23:0] d);
    valid = 1'b1; auto_m = au; sel = s; din = d;
    model_write(au, s, d);
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Issues a commit (optionally with a same-cycle write), pushes the expected bank and
  // observes the lockout. Optionally drives junk writes/commits during HOLD.
  task automatic run_commit(input bit wr, input bit au, input logic [1:0] s,
                            input logic [23:0] d, input bit junk,
                            output int low, output int dones, output logic [95:0] rgb2,
                            output logic rdy_after);
    if (wr) begin
      valid = 1'b1; auto_m = au; sel = s; din = d;
      model_write(au, s, d);
    end
    commit = 1'b1;
    exp_q.push_back(model_bank());
`ifdef RGB_DEMUX_CLEAR_ON_COMMIT_EN
    for (int k = 0; k < 4; k++) m_sh[k] = '0;
`endif
    m_ptr = 0;
    low = 0; dones = 0; rgb2 = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      valid = 1'b0; commit = 1'b0;
      if (i == 2) rgb2 = rgb;
      dones += int'(done);
      if (junk && i >= 2 && i <= 10) begin
        valid = 1'b1; auto_m = 1'b0; sel = 2'd0; din = 24'hDEADBE; commit = 1'b1;
      end
      if (ready) break;
      low++;
    end
    valid = 1'b0; commit = 1'b0;
    @(negedge clk);
    dones += int'(done);
    rdy_after = ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || d3_ready !== 1'b0) $display("FAIL reset_ready_low: got %b/%b want 0/0", ready, d3_ready);
    else passed++;
    checks++;
    if (rgb !== '0) $display("FAIL reset_rgb: got %h want 0", rgb);
    else passed++;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || d3_ready !== 1'b1) $display("FAIL post_reset_ready: got %b/%b want 1/1", ready, d3_ready);
    else passed++;
    checks++;
    if (done !== 1'b0 || err !== 1'b0) $display("FAIL post_reset_pulses: got done=%b err=%b want 0 0", done, err);
    else passed++;
  endtask

  task automatic test_manual();
    int low, dones; logic [95:0] r2, ex; logic ra;
    do_write(1'b0, 2'd0, 24'hFF0000);
    do_write(1'b0, 2'd2, 24'h00FF00);
    run_commit(1'b0, 1'b0, 2'd0, 24'h0, 1'b0, low, dones, r2, ra);
    ex = exp_q.pop_front();
    checks++;
    if (r2 !== ex) $display("FAIL manual_rgb: got %h want %h", r2, ex);
    else passed++;
    checks++;
    if (r2 !== {24'h0, 24'h00FF00, 24'h0, 24'hFF0000}) $display("FAIL manual_rgb_const: got %h want %h", r2, {24'h0, 24'h00FF00, 24'h0, 24'hFF0000});
    else passed++;
    checks++;
    if (low != 17) $display("FAIL manual_lockout: got %0d want 17", low);
    else passed++;
    checks++;
    if (dones != 1) $display("FAIL manual_done_pulses: got %0d want 1", dones);
    else passed++;
  endtask

  task automatic test_auto();
    int low, dones; logic [95:0] r2, ex; logic ra;
    do_write(1'b1, 2'd0, 24'hAAAAAA);
    do_write(1'b1, 2'd0, 24'hBBBBBB);
    do_write(1'b1, 2'd0, 24'hCCCCCC);
    do_write(1'b1, 2'd0, 24'hDDDDDD);
    do_write(1'b1, 2'd0, 24'hEEEEEE);
    run_commit(1'b0, 1'b0, 2'd0, 24'h0, 1'b0, low, dones, r2, ra);
    ex = exp_q.pop_front();
    checks++;
    if (r2 !== {24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hEEEEEE}) $display("FAIL auto_wrap: got %h want %h", r2, ex);
    else passed++;
    do_write(1'b1, 2'd0, 24'h0F0F0F);
    run_commit(1'b0, 1'b0, 2'd0, 24'h0, 1'b0, low, dones, r2, ra);
    ex = exp_q.pop_front();
    checks++;
    if (r2 !== ex) $display("FAIL auto_ptr_restart: got %h want %h", r2, ex);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int low, dones; logic [95:0] r2, ex; logic ra;
    run_commit(1'b1, 1'b0, 2'd1, 24'h123456, 1'b1, low, dones, r2, ra);
    ex = exp_q.pop_front();
    checks++;
    if (r2 !== ex) $display("FAIL same_cycle_bank: got %h want %h", r2, ex);
    else passed++;
    checks++;
    if (r2[47:24] !== 24'h123456) $display("FAIL same_cycle_ch1: got %h want 123456", r2[47:24]);
    else passed++;
    checks++;
    if (low != 17 || dones != 1) $display("FAIL hold_junk_lockout: got low=%0d done=%0d want 17 1", low, dones);
    else passed++;
    checks++;
    if (ra !== 1'b1) $display("FAIL hold_commit_ignored: got ready=%b want 1", ra);
    else passed++;
    run_commit(1'b0, 1'b0, 2'd0, 24'h0, 1'b0, low, dones, r2, ra);
    ex = exp_q.pop_front();
    checks++;
    if (r2 !== ex) $display("FAIL hold_write_dropped: got %h want %h", r2, ex);
    else passed++;
  endtask

  task automatic test_clear();
    int low, dones; logic [95:0] r2, ex, prev; logic ra;
    do_write(1'b0, 2'd0, 24'h010101);
    do_write(1'b0, 2'd1, 24'h020202);
    do_write(1'b0, 2'd2, 24'h030303);
    run_commit(1'b0, 1'b0, 2'd0, 24'h0, 1'b0, low, dones, prev, ra);
    ex = exp_q.pop_front();
    checks++;
    if (prev !== ex) $display("FAIL clear_first_bank: got %h want %h", prev, ex);
    else passed++;
    do_write(1'b0, 2'd3, 24'hABCDEF);
    run_commit(1'b0, 1'b0, 2'd0, 24'h0, 1'b0, low, dones, r2, ra);
    ex = exp_q.pop_front();
    checks++;
`ifdef RGB_DEMUX_CLEAR_ON_COMMIT_EN
    if (r2 !== {24'hABCDEF, 72'h0}) $display("FAIL clear_bank: got %h want %h", r2, {24'hABCDEF, 72'h0});
`else
    if (r2 !== {24'hABCDEF, prev[71:0]}) $display("FAIL retain_bank: got %h want %h", r2, {24'hABCDEF, prev[71:0]});
`endif
    else passed++;
    checks++;
    if (r2 !== ex) $display("FAIL clear_model: got %h want %h", r2, ex);
    else passed++;
  endtask

  task automatic test_err_nohold();
    int errs;
    errs = 0;
    d3_valid = 1'b1; d3_auto = 1'b0;
    d3_sel = 2'd0; d3_din = 24'h111111; @(negedge clk); errs += int'(d3_err);
    d3_sel = 2'd1; d3_din = 24'h222222; @(negedge clk); errs += int'(d3_err);
    d3_sel = 2'd2; d3_din = 24'h333333; @(negedge clk); errs += int'(d3_err);
    d3_sel = 2'd3; d3_din = 24'h444444; @(negedge clk);
    d3_valid = 1'b0;
    checks++;
    if (d3_err !== 1'b1) $display("FAIL err_pulse: got %b want 1", d3_err);
    else passed++;
    @(negedge clk);
    checks++;
    if (d3_err !== 1'b0 || errs != 0) $display("FAIL err_single: got err=%b early=%0d want 0 0", d3_err, errs);
    else passed++;
    d3_commit = 1'b1;
    @(negedge clk);
    d3_commit = 1'b0;
    checks++;
    if (d3_ready !== 1'b0 || d3_done !== 1'b0) $display("FAIL nohold_commit_cycle: got ready=%b done=%b want 0 0", d3_ready, d3_done);
    else passed++;
    @(negedge clk);
    checks++;
    if (d3_rgb !== {24'h333333, 24'h222222, 24'h111111}) $display("FAIL err_bank: got %h want %h", d3_rgb, {24'h333333, 24'h222222, 24'h111111});
    else passed++;
    checks++;
    if (d3_ready !== 1'b1 || d3_done !== 1'b1) $display("FAIL nohold_done: got ready=%b done=%b want 1 1", d3_ready, d3_done);
    else passed++;
    @(negedge clk);
    checks++;
    if (d3_done !== 1'b0) $display("FAIL nohold_done_single: got %b want 0", d3_done);
    else passed++;
  endtask

  task automatic test_reset_mid_hold();
    int dones;
    do_write(1'b0, 2'd0, 24'h55AA55);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || rgb[23:0] !== 24'h55AA55) $display("FAIL mid_hold_state: got ready=%b ch0=%h want 0 55aa55", ready, rgb[23:0]);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || rgb !== '0) $display("FAIL mid_hold_reset: got ready=%b rgb=%h want 0 0", ready, rgb);
    else passed++;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) $display("FAIL after_abort: got ready=%b done=%b want 1 0", ready, done);
    else passed++;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      dones += int'(done);
    end
    checks++;
    if (dones != 0 || ready !== 1'b1) $display("FAIL abort_no_done: got dones=%0d ready=%b want 0 1", dones, ready);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; din = '0; valid = 1'b0; sel = '0; auto_m = 1'b0; commit = 1'b0;
    d3_din = '0; d3_valid = 1'b0; d3_sel = '0; d3_auto = 1'b0; d3_commit = 1'b0;
    model_reset();
    test_reset();
    test_manual();
    test_auto();
    test_back_to_back();
    test_clear();
    test_err_nohold();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
